// File: rtl/multi_cycle_controller.sv
// Moore control FSM for a multi-cycle MIPS datapath with a shared, handshaked memory.
// Decodes Op, drives every datapath select/enable, counts retired instructions, halts on HALT/illegal.
module multi_cycle_controller #(
  parameter int CNT_W  = 32,
  parameter bit MEM_HS = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [5:0]       Op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstCount,
  output logic             Halted,
  output logic             Illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    HALT   = 4'd12
  } state_t;

  state_t           state, state_n;
  logic             illegal, illegal_n;
  logic [CNT_W-1:0] inst_cnt;
  logic             mr;
  logic             retire;

  assign mr = MEM_HS ? MemReady : 1'b1;

  always_comb begin
    state_n   = state;
    illegal_n = illegal;
    case (state)
      FETCH:  if (mr) state_n = DECODE;
      DECODE: begin
        case (Op)
          6'b000000: state_n = EXEC;
          6'b100011,
          6'b101011: state_n = MEMADR;
          6'b000100: state_n = BRANCH;
          6'b000010: state_n = JUMP;
          6'b001000: state_n = ADDIEX;
          6'b111111: state_n = HALT;
          default: begin
            state_n   = HALT;
            illegal_n = 1'b1;
          end
        endcase
      end
      MEMADR: state_n = (Op == 6'b101011) ? MEMWR : MEMRD;
      MEMRD:  if (mr) state_n = MEMWB;
      MEMWR:  if (mr) state_n = FETCH;
      EXEC:   state_n = RWB;
      ADDIEX: state_n = ADDIWB;
      MEMWB, RWB, BRANCH, JUMP, ADDIWB: state_n = FETCH;
      HALT:   state_n = HALT;
      default: begin
        state_n   = HALT;
        illegal_n = 1'b1;
      end
    endcase
  end

  // An instruction retires on any entry into FETCH from another state.
  assign retire = (state != FETCH) && (state_n == FETCH);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= FETCH;
      illegal  <= 1'b0;
      inst_cnt <= '0;
    end else begin
      state   <= state_n;
      illegal <= illegal_n;
      if (retire) inst_cnt <= inst_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Decoded straight from state and gated by Reset, so FETCH strobes are valid the
  // first cycle after release and every enable drops the instant Reset falls.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    Halted      = 1'b0;
    if (Reset) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mr;
          PCWrite = mr;
        end
        DECODE: ALUSrcB = 2'b11;
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCSource    = 2'b01;
          PCWriteCond = 1'b1;
        end
        JUMP: begin
          PCSource = 2'b10;
          PCWrite  = 1'b1;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ADDIWB: RegWrite = 1'b1;
        HALT:   Halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign PCEn      = PCWrite | (PCWriteCond & Zero);
  assign State     = state;
  assign InstCount = inst_cnt;
  assign Illegal   = illegal;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: stimulus pushes the expected per-cycle response, a negedge monitor pops and compares.
module tb_multi_cycle_controller;

  localparam int CNT_W = 4;

  logic             Clock, Reset, Zero, MemReady;
  logic [5:0]       Op;
  logic             PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA, Halted, Illegal;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstCount;

  multi_cycle_controller #(.CNT_W(CNT_W), .MEM_HS(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .State(State), .InstCount(InstCount),
    .Halted(Halted), .Illegal(Illegal)
  );

  typedef struct {
    logic [3:0]       st;
    logic [CNT_W-1:0] cnt;
    logic [18:0]      ctl;
  } rec_t;

  rec_t exp_q[$];
  rec_t r;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_HALT = 6'b111111, OP_BAD = 6'b010101;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference control word from the state/output table.
  // {PCWrite,PCWriteCond,PCEn,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
  //  ALUSrcA,ALUSrcB,ALUOp,PCSource,Halted,Illegal}
  function automatic logic [18:0] ctl_exp(input int st, input bit mr, input bit z, input bit ill);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, hlt;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, hlt} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pcwc = 1; end
      9:  begin psrc = 2'b10; pcw = 1; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      12: hlt = 1;
      default: ;
    endcase
    return {pcw, pcwc, pcw | (pcwc & z), iord, mrd, mwr, irw, m2r, rd, rw, asa,
            asb, aop, psrc, hlt, ill};
  endfunction

  task automatic step(input bit rst, input logic [5:0] op, input bit z, input bit mr,
                      input int st, input int cnt, input bit ill);
    rec_t e;
    Reset = rst; Op = op; Zero = z; MemReady = mr;
    e.st  = 4'(st);
    e.cnt = CNT_W'(cnt);
    e.ctl = rst ? ctl_exp(st, mr, z, ill) : 19'd0;
    exp_q.push_back(e);
    @(posedge Clock); #1;
  endtask

  always @(negedge Clock) begin
    cyc++;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      checks += 3;
      if (State !== r.st) begin
        errors++;
        $display("FAIL state cyc=%0d got=%0d want=%0d", cyc, State, r.st);
      end
      if (InstCount !== r.cnt) begin
        errors++;
        $display("FAIL inst_count cyc=%0d got=%0d want=%0d", cyc, InstCount, r.cnt);
      end
      if ({PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Halted, Illegal} !== r.ctl) begin
        errors++;
        $display("FAIL controls cyc=%0d state=%0d got=%b want=%b", cyc, State,
                 {PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Halted, Illegal}, r.ctl);
      end
    end
  end

  initial begin
    int c;
    Reset = 1'b0; Op = OP_R; Zero = 1'b0; MemReady = 1'b1;
    @(posedge Clock); #1;
    // reset held 3 cycles: everything 0 even with MemReady high in FETCH
    repeat (3) step(0, OP_R, 0, 1, 0, 0, 0);
    // R-type: 0,1,6,7 -> 0
    step(1, OP_R, 0, 1, 0, 0, 0);
    step(1, OP_R, 0, 1, 1, 0, 0);
    step(1, OP_R, 0, 1, 6, 0, 0);
    step(1, OP_R, 0, 1, 7, 0, 0);
    // lw with two MEMRD stalls
    step(1, OP_LW, 0, 1, 0, 1, 0);
    step(1, OP_LW, 0, 1, 1, 1, 0);
    step(1, OP_LW, 0, 1, 2, 1, 0);
    step(1, OP_LW, 0, 0, 3, 1, 0);
    step(1, OP_LW, 0, 0, 3, 1, 0);
    step(1, OP_LW, 0, 1, 3, 1, 0);
    step(1, OP_LW, 0, 1, 4, 1, 0);
    // beq taken then not taken
    step(1, OP_BEQ, 1, 1, 0, 2, 0);
    step(1, OP_BEQ, 1, 1, 1, 2, 0);
    step(1, OP_BEQ, 1, 1, 8, 2, 0);
    step(1, OP_BEQ, 0, 1, 0, 3, 0);
    step(1, OP_BEQ, 0, 1, 1, 3, 0);
    step(1, OP_BEQ, 0, 1, 8, 3, 0);
    // sw with one MEMWR stall
    step(1, OP_SW, 0, 1, 0, 4, 0);
    step(1, OP_SW, 0, 1, 1, 4, 0);
    step(1, OP_SW, 0, 1, 2, 4, 0);
    step(1, OP_SW, 0, 0, 5, 4, 0);
    step(1, OP_SW, 0, 1, 5, 4, 0);
    // addi with a FETCH stall first
    step(1, OP_ADDI, 0, 0, 0, 5, 0);
    step(1, OP_ADDI, 0, 1, 0, 5, 0);
    step(1, OP_ADDI, 0, 1, 1, 5, 0);
    step(1, OP_ADDI, 0, 1, 10, 5, 0);
    step(1, OP_ADDI, 0, 1, 11, 5, 0);
    // 16 jumps: 4-bit counter wraps 15 -> 0 and lands back on 6
    c = 6;
    for (int i = 0; i < 16; i++) begin
      step(1, OP_J, 0, 1, 0, c, 0);
      step(1, OP_J, 0, 1, 1, c, 0);
      step(1, OP_J, 0, 1, 9, c, 0);
      c = (c + 1) % 16;
    end
    // reset during a stalled MEMWR: MemWrite must drop within the same cycle
    step(1, OP_SW, 0, 1, 0, 6, 0);
    step(1, OP_SW, 0, 1, 1, 6, 0);
    step(1, OP_SW, 0, 1, 2, 6, 0);
    step(1, OP_SW, 0, 0, 5, 6, 0);
    step(0, OP_SW, 0, 0, 0, 0, 0);
    step(0, OP_SW, 0, 0, 0, 0, 0);
    step(1, OP_ADDI, 0, 1, 0, 0, 0);
    step(1, OP_ADDI, 0, 1, 1, 0, 0);
    step(1, OP_ADDI, 0, 1, 10, 0, 0);
    step(1, OP_ADDI, 0, 1, 11, 0, 0);
    // legal HALT: no Illegal, no retire
    step(1, OP_HALT, 0, 1, 0, 1, 0);
    step(1, OP_HALT, 0, 1, 1, 1, 0);
    repeat (3) step(1, OP_HALT, 1, 1, 12, 1, 0);
    step(0, OP_R, 0, 1, 0, 0, 0);
    // retire one R-type, then an illegal opcode parks in HALT for 20 cycles
    step(1, OP_R, 0, 1, 0, 0, 0);
    step(1, OP_R, 0, 1, 1, 0, 0);
    step(1, OP_R, 0, 1, 6, 0, 0);
    step(1, OP_R, 0, 1, 7, 0, 0);
    step(1, OP_BAD, 0, 1, 0, 1, 0);
    step(1, OP_BAD, 0, 1, 1, 1, 0);
    repeat (20) step(1, OP_BAD, 1, 1, 12, 1, 1);
    // reset clears Illegal and returns to FETCH
    step(0, OP_R, 0, 1, 0, 0, 0);
    step(1, OP_R, 0, 1, 0, 0, 0);
    step(1, OP_R, 0, 1, 1, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
